// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one registered stage per shift-distance bit, with a
// valid/ready handshake on both ends and bubble-collapsing per-stage advance.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [2:0] {
    MODE_ROL = 3'd0,
    MODE_SLL = 3'd1,
    MODE_ROR = 3'd2,
    MODE_SRL = 3'd3,
    MODE_SRA = 3'd4
  } mode_e;

  // Sign is the original operand MSB, captured at stage 0, so later SRA stages
  // fill with it rather than with the partially shifted MSB.
  function automatic logic [WIDTH-1:0] stage_op(input logic [WIDTH-1:0] d,
                                                input logic             en,
                                                input logic [2:0]       mode,
                                                input logic             sign,
                                                input int unsigned      s);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] r;
    ones = '1;
    r    = d;
    if (en) begin
      case (mode)
        MODE_ROL: r = (d << s) | (d >> (WIDTH - s));
        MODE_SLL: r = d << s;
        MODE_ROR: r = (d >> s) | (d << (WIDTH - s));
        MODE_SRL: r = d >> s;
        MODE_SRA: r = (d >> s) | (sign ? ~(ones >> s) : '0);
        default:  r = d;
      endcase
    end
    return r;
  endfunction

  logic [CNT_W-1:0] vld_q, vld_d;
  logic [CNT_W-1:0] sign_q, sign_d;
  logic [WIDTH-1:0] data_q [CNT_W];
  logic [WIDTH-1:0] data_d [CNT_W];
  logic [CNT_W-1:0] cnt_q  [CNT_W];
  logic [CNT_W-1:0] cnt_d  [CNT_W];
  logic [2:0]       mode_q [CNT_W];
  logic [2:0]       mode_d [CNT_W];

  logic [CNT_W-1:0] adv;
  logic [CNT_W-1:0] src_vld;
  logic [CNT_W-1:0] src_sign;
  logic [WIDTH-1:0] src_data [CNT_W];
  logic [CNT_W-1:0] src_cnt  [CNT_W];
  logic [2:0]       src_mode [CNT_W];

  always_comb begin
    logic take;
    int unsigned k;
    adv      = '0;
    src_vld  = '0;
    src_sign = '0;
    vld_d    = vld_q;
    sign_d   = sign_q;
    for (int unsigned i = 0; i < CNT_W; i++) begin
      src_data[i] = '0;
      src_cnt[i]  = '0;
      src_mode[i] = '0;
      data_d[i]   = data_q[i];
      cnt_d[i]    = cnt_q[i];
      mode_d[i]   = mode_q[i];
    end

    // A stage may load if empty or if its content moves on this same cycle.
    take = out_ready;
    for (int unsigned i = 0; i < CNT_W; i++) begin
      k      = CNT_W - 1 - i;
      adv[k] = !vld_q[k] || take;
      take   = adv[k];
    end

    src_vld[0]  = in_valid;
    src_data[0] = in_data;
    src_cnt[0]  = in_cnt;
    src_mode[0] = in_mode;
    src_sign[0] = in_data[WIDTH-1];
    for (int unsigned i = 1; i < CNT_W; i++) begin
      src_vld[i]  = vld_q[i-1];
      src_data[i] = data_q[i-1];
      src_cnt[i]  = cnt_q[i-1];
      src_mode[i] = mode_q[i-1];
      src_sign[i] = sign_q[i-1];
    end

    for (int unsigned i = 0; i < CNT_W; i++) begin
      if (adv[i]) begin
        vld_d[i] = src_vld[i];
        if (src_vld[i]) begin
          data_d[i] = stage_op(src_data[i], src_cnt[i][i], src_mode[i],
                               src_sign[i], 32'd1 << i);
          cnt_d[i]  = src_cnt[i];
          mode_d[i] = src_mode[i];
          sign_d[i] = src_sign[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      sign_q <= '0;
      for (int unsigned i = 0; i < CNT_W; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
        mode_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      sign_q <= sign_d;
      for (int unsigned i = 0; i < CNT_W; i++) begin
        data_q[i] <= data_d[i];
        cnt_q[i]  <= cnt_d[i];
        mode_q[i] <= mode_d[i];
      end
    end
  end

  assign in_ready  = rst_n & adv[0];
  assign out_valid = vld_q[CNT_W-1];
  assign out_data  = data_q[CNT_W-1];
  assign busy      = |vld_q;

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, fully pipelined barrel shifter for the execute-stage shift/rotate path.
- Replaces the fixed 16-bit, single-distance combinational shift stages.
- Supports five modes: rotate left/right, logical left/right, arithmetic right.
- One registered stage per shift-distance bit. Valid/ready handshake on both sides, so the core can stall it.

Parameters:
WIDTH, 16, data width; must be a power of two, >= 4.
CNT_W, $clog2(WIDTH), shift-count width and number of pipeline stages.

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  input operand valid.
in_ready  output  1  shifter can accept an operand this cycle.
in_data  input  WIDTH  operand.
in_cnt  input  CNT_W  shift distance, 0..WIDTH-1.
in_mode  input  3  0=ROL, 1=SLL, 2=ROR, 3=SRL, 4=SRA, 5-7=pass-through.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
out_data  output  WIDTH  shifted result.
busy  output  1  at least one stage holds a valid operand.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid bits clear; out_valid=0, busy=0, out_data=0.
  - in_ready=1 once rst_n is high; in_ready=0 while rst_n is low.
  - in-flight operands are discarded, not completed.
- Stages 0..CNT_W-1. Each stage holds a register set {valid, data, cnt, mode}.
- Stage k applies a shift/rotate of 2^k positions when cnt[k]=1 and passes data unchanged when cnt[k]=0.
- Input transfer: in_valid & in_ready loads stage 0 with stage-0 processing applied to in_data.
- Output transfer: out_valid & out_ready. out_valid = valid of the last stage; out_data = data of the last stage.
- Per-stage advance: stage k may load when it is empty or stage k+1 (or the consumer, for the last stage) takes its contents in the same cycle.
  - in_ready equals stage 0's advance condition (combinational from the stage valids and out_ready).
  - Bubbles collapse: an empty stage loads even while downstream is stalled.
- Latency: exactly CNT_W cycles from input transfer to out_valid with no backpressure (4 for WIDTH=16). Throughput is one operand per cycle.
- Simultaneous input transfer and output transfer in a full pipe: both occur, no loss, occupancy unchanged.
- Ordering: results leave in acceptance order. No operand is dropped or duplicated under any out_ready pattern.
- Stall: while a stage holds valid and cannot advance, its registers keep their values.
- Empty stages: data content is don't-care, but out_data must not change while out_valid=1 and out_ready=0.
- Mode rules, per stage shift of s=2^k:
  - ROL: bits wrap from MSB to LSB.
  - ROR: bits wrap from LSB to MSB. Every ROR bit must come from the source operand (no wrong-bit wrap).
  - SLL: zero fill at the LSB end.
  - SRL: zero fill at the MSB end.
  - SRA: fill at the MSB end with the original operand MSB. That bit is captured in stage 0 and carried with the operand.
  - Modes 5-7: result = in_data regardless of cnt.
- in_cnt=0 in any mode: result = in_data.
- busy = OR of all stage valid bits.

Test Plan:
- Reset then single operands, WIDTH=16, out_ready=1 (each result 4 cycles after acceptance):
  - SRA 0x8000 cnt 2 -> 0xE000
  - SRL 0x8000 cnt 15 -> 0x0001
  - SLL 0x00FF cnt 4 -> 0x0FF0
  - ROR 0x0001 cnt 2 -> 0x4000
  - ROL 0x8001 cnt 1 -> 0x0003
  - mode 6 0x1234 cnt 7 -> 0x1234
- Back-to-back stream of 8 operands with out_ready=1: one result per cycle starting cycle 4, in order, in_ready held at 1.
- Backpressure: drive 6 operands, out_ready=0 from cycle 3 for 5 cycles:
  - in_ready drops after 4 operands held.
  - out_data is stable while stalled.
  - after release, all 6 results emerge in order with correct values.
- Bubble collapse: one operand accepted, out_ready=0, then 3 more operands on consecutive cycles → all accepted (pipe fills to 4), in_ready=0 next cycle.
- Reset mid-flight: 3 operands in pipe, pulse rst_n low asynchronously between clock edges:
  - out_valid=0 and busy=0 immediately.
  - after release, the first new operand returns after exactly 4 cycles with its correct result.
- Exhaustive sweep: random data, all cnt 0..15, modes 0-4, compared against a reference model with random out_ready → zero mismatches.
